// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler that time-shares one external 8-bit adder among NUM_REQ
// requesters, chaining multi-byte add/sub ops byte by byte. Optional: ADDSCHED_SAT_EN.
module adder_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WORDS   = 2,
    parameter int IDW     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*8*WORDS-1:0] req_a,
    input  logic [NUM_REQ*8*WORDS-1:0] req_b,
    input  logic [NUM_REQ-1:0]     req_sub,
    output logic [7:0]             add_a,
    output logic [7:0]             add_b,
    output logic                   add_cin,
    input  logic [7:0]             add_s,
    input  logic                   add_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [8*WORDS-1:0]     rsp_data,
    output logic                   rsp_cout,
    output logic [IDW-1:0]         rsp_id
);
    localparam int W  = 8 * WORDS;
    localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [BW-1:0]  LAST_BYTE = BW'(WORDS - 1);
    localparam logic [IDW-1:0] LAST_REQ  = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [IDW-1:0] rr_ptr, gnt_q, gnt_idx;
    logic           gnt_found;
    logic [BW-1:0]  byte_idx;
    logic           carry, sub_q;
    logic [W-1:0]   a_q, b_q, result, result_next;
    logic           accept, last_byte;
    int             idx;

    // Search from rr_ptr upward, wrapping, for the first valid requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[IDW-1:0];
            end
        end
    end

    assign accept    = (state == IDLE) && gnt_found && !rst;
    assign last_byte = (byte_idx == LAST_BYTE);

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_found) state_next = RUN;
            RUN:     if (last_byte) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The adder is only driven while a byte is in flight.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_q[8*byte_idx +: 8];
            add_b   = sub_q ? ~b_q[8*byte_idx +: 8] : b_q[8*byte_idx +: 8];
            add_cin = carry;
        end
    end

    always_comb begin
        result_next = result;
        result_next[8*byte_idx +: 8] = add_s;
`ifdef ADDSCHED_SAT_EN
        // Clamp on the last byte; the raw carry is still reported on rsp_cout.
        if (last_byte) begin
            if (!sub_q && add_cout)     result_next = '1;
            else if (sub_q && !add_cout) result_next = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            gnt_q    <= '0;
            byte_idx <= '0;
            carry    <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_found) begin
                    a_q      <= req_a[gnt_idx*W +: W];
                    b_q      <= req_b[gnt_idx*W +: W];
                    sub_q    <= req_sub[gnt_idx];
                    gnt_q    <= gnt_idx;
                    byte_idx <= '0;
                    carry    <= req_sub[gnt_idx];
                end
                RUN: begin
                    result <= result_next;
                    carry  <= add_cout;
                    if (!last_byte) byte_idx <= byte_idx + 1'b1;
                end
                DONE: if (rsp_ready) begin
                    rr_ptr <= (gnt_q == LAST_REQ) ? '0 : gnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_data  = result;
    assign rsp_cout  = (state == DONE) && carry;
    assign rsp_id    = gnt_q;
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: table-driven ops plus hand-written
// round-robin, subtract-probe, backpressure and mid-run reset sequences.
module tb_adder_rr_scheduler;
    localparam int NUM_REQ = 4;
    localparam int WORDS   = 2;
    localparam int IDW     = 2;
    localparam int W       = 8 * WORDS;
    localparam int EW      = IDW + 1 + W;
`ifdef ADDSCHED_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*W-1:0]   req_a = '0;
    logic [NUM_REQ*W-1:0]   req_b = '0;
    logic [NUM_REQ-1:0]     req_sub = '0;
    logic [7:0]             add_a, add_b, add_s;
    logic                   add_cin, add_cout;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b1;
    logic [W-1:0]           rsp_data;
    logic                   rsp_cout;
    logic [IDW-1:0]         rsp_id;

    adder_rr_scheduler #(.NUM_REQ(NUM_REQ), .WORDS(WORDS), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
    );

    // External ripple-carry adder shared by all requesters.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int fails  = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL rsp_unexpected: got id %0d data %0h, required no response", rsp_id, rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(mon_e[W-1:0]));
                check("rsp_cout", 32'(rsp_cout), 32'(mon_e[W]));
                check("rsp_id",   32'(rsp_id),   32'(mon_e[EW-1:W+1]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_sub[id]      = s;
        req_valid[id]    = 1'b1;
    endtask

    task automatic wait_grant(input int id, input string name, output bit ok);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[id] && n < 30);
        check(name, 32'(req_ready), 32'(1) << id);
        ok = req_ready[id];
    endtask

    task automatic push_exp(input int id, input logic c, input logic [W-1:0] d);
        logic [IDW-1:0] idv;
        idv = IDW'(id);
        exp_q.push_back({idv, c, d});
    endtask

    task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] ed, input logic ec);
        int n;
        bit ok;
        set_req(id, a, b, s);
        wait_grant(id, "op_grant", ok);
        if (!ok) begin
            req_valid[id] = 1'b0;
            return;
        end
        push_exp(id, ec, ed);
        @(posedge clk); #1 req_valid[id] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        check("rsp_latency", 32'(n), 32'd3);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_data;
        logic [W-1:0] exp_sat;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[8];
    int   rr_order[5];
    logic [W-1:0] rr_a[4], rr_b[4], rr_exp[4];

    initial begin
        int  last;
        bit  ok;
        int  seen;

        vecs[0] = '{1, 16'h01FF, 16'h0001, 1'b0, 16'h0200, 16'h0200, 1'b0};
        vecs[1] = '{0, 16'h0100, 16'h0001, 1'b1, 16'h00FF, 16'h00FF, 1'b1};
        vecs[2] = '{2, 16'hFFFF, 16'h0002, 1'b0, 16'h0001, 16'hFFFF, 1'b1};
        vecs[3] = '{3, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 16'h0000, 1'b0};
        vecs[4] = '{1, 16'h1234, 16'h4321, 1'b0, 16'h5555, 16'h5555, 1'b0};
        vecs[5] = '{0, 16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[6] = '{2, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 16'h0100, 1'b0};
        vecs[7] = '{3, 16'h1000, 16'h2000, 1'b1, 16'hF000, 16'h0000, 1'b0};
        rr_order = '{0, 1, 2, 3, 0};
        rr_a   = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
        rr_b   = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        rr_exp = '{16'h1011, 16'h2022, 16'h3033, 16'h4044};

        // Reset values
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_add_bus",   32'({add_a, add_b, add_cin}), 32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Round-robin with every requester valid continuously
        for (int i = 0; i < NUM_REQ; i++) set_req(i, rr_a[i], rr_b[i], 1'b0);
        last = 0;
        for (int g = 0; g < 5; g++) begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (req_ready == '0 && n < 30);
            check("rr_grant", 32'(req_ready), 32'(1) << rr_order[g]);
            if (g > 0) check("rr_interval", 32'(cyc - last), 32'd4);
            last = cyc;
            push_exp(rr_order[g], 1'b0, rr_exp[rr_order[g]]);
            @(posedge clk); #1;
            if (g == 4) req_valid = '0;
        end
        drain();

        // Table-driven single operations
        for (int v = 0; v < 8; v++)
            do_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sub,
                  SAT ? vecs[v].exp_sat : vecs[v].exp_data, vecs[v].exp_cout);

        // Subtract: probe the bytes presented to the adder
        set_req(0, 16'h0100, 16'h0001, 1'b1);
        wait_grant(0, "sub_grant", ok);
        push_exp(0, 1'b1, 16'h00FF);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("sub_b0_add", 32'({add_a, add_b, add_cin}), {15'd0, 8'h00, 8'hFE, 1'b1});
        @(negedge clk);
        check("sub_b1_add", 32'({add_a, add_b, add_cin}), {15'd0, 8'h01, 8'hFF, 1'b0});
        @(negedge clk);
        check("sub_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;

        // Backpressure with requester 2 pending
        rsp_ready = 1'b0;
        set_req(1, 16'h0203, 16'h0405, 1'b0);
        wait_grant(1, "bp_grant1", ok);
        push_exp(1, 1'b0, 16'h0608);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        set_req(2, 16'h7000, 16'h0FFF, 1'b0);
        seen = 0;
        do begin @(negedge clk); seen++; end while (!rsp_valid && seen < 20);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_data",  32'(rsp_data),  32'h0608);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_grant2_next", 32'(req_ready), 32'h4);
        push_exp(2, 1'b0, 16'h7FFF);
        @(posedge clk); #1 req_valid[2] = 1'b0;
        drain();

        // Reset during RUN byte 0
        set_req(3, 16'h1234, 16'h5678, 1'b0);
        wait_grant(3, "rst_grant3", ok);
        @(posedge clk); #1;
        set_req(1, 16'h0005, 16'h0003, 1'b0);
        set_req(3, 16'h0100, 16'h0001, 1'b1);
        check("run_b0_add", 32'({add_a, add_b}), 32'h3478);
        #2 rst = 1'b1;
        #1;
        check("arst_add_bus",   32'({add_a, add_b, add_cin}), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_rsp",       32'({rsp_valid, rsp_cout, rsp_id}), 32'd0);
        check("arst_rsp_data",  32'(rsp_data), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_grant_from0", 32'(req_ready), 32'h2);
        push_exp(1, 1'b0, 16'h0008);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_grant(3, "post_rst_grant3", ok);
        push_exp(3, 1'b1, 16'h00FF);
        @(posedge clk); #1 req_valid[3] = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Time-shares one external 8-bit ripple-carry adder (A, B, Cin -> S, Cout) among NUM_REQ requesters in the Laplace filter datapath.
- Each request is a WORDS-byte add or subtract. The scheduler chains it byte by byte through the adder, holding the carry in a register between passes.
- Grants are round-robin. Requests and responses each use a valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORDS, 2, operand width in bytes; operand width W = 8*WORDS.
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NUM_REQ.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*W  operand A; requester i uses slice [i*W +: W].
- req_b  in  NUM_REQ*W  operand B; same slicing as req_a.
- req_sub  in  NUM_REQ  1 = compute A-B, 0 = compute A+B.
- add_a  out  8  byte to adder A.
- add_b  out  8  byte to adder B; already inverted when subtracting.
- add_cin  out  1  adder carry-in.
- add_s  in  8  adder sum.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  W  result.
- rsp_cout  out  1  final carry. For add this is the carry-out; for sub it is the not-borrow (1 = A>=B unsigned).
- rsp_id  out  IDW  index of the requester served.

Behaviour:
- Reset (async, rst=1). state=IDLE, rr_ptr=0, byte_idx=0, carry=0. All outputs 0: req_ready, rsp_valid, rsp_data, rsp_cout, rsp_id, add_a, add_b, add_cin.
- IDLE.
  - Grant the first asserted req_valid searching from rr_ptr upward, wrapping at NUM_REQ.
  - req_ready[g] is combinational and high only in IDLE for the granted index.
  - On the accept edge, latch A, B, sub and g, set byte_idx=0 and carry=sub, then go to RUN.
  - No request pending: stay in IDLE.
- RUN.
  - add_a = A[8*byte_idx +: 8].
  - add_b = sub ? ~B byte : B byte.
  - add_cin = carry.
  - Adder is combinational; capture add_s into result byte byte_idx and add_cout into carry at each edge.
  - byte_idx == WORDS-1: go to DONE. Otherwise byte_idx increments.
  - Outside RUN, add_a, add_b and add_cin are driven to 0.
- DONE.
  - rsp_valid=1.
  - rsp_data, rsp_cout and rsp_id stay stable until the handshake.
  - rsp_valid && rsp_ready: rsp_valid drops next cycle, rr_ptr = (g+1) mod NUM_REQ, return to IDLE.
- Latency. Accept at edge T. RUN occupies cycles T+1..T+WORDS. rsp_valid is high from cycle T+WORDS+1. Back-to-back throughput is one operation per WORDS+2 cycles with rsp_ready tied high.
- Fairness. A requester holding valid is granted within NUM_REQ grants.
- Requester protocol. Requesters must keep valid and data stable until ready. A requester that drops valid before grant is simply skipped.
- Reset mid-operation aborts immediately: partial result discarded, no response issued.
- rsp_ready high outside DONE is ignored.
- Wrap-around.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Sum overflow wraps modulo 2**W; the overflow is reported only via rsp_cout.

Optional Feature:
- Macro ADDSCHED_SAT_EN.
- Defined: unsigned saturation is applied at DONE entry.
  - add with final carry=1: rsp_data = all ones.
  - sub with final carry=0 (borrow): rsp_data = 0.
  - rsp_cout still reports the raw carry.
- Undefined: result wraps modulo 2**W. No saturation logic is present.

Test Plan:
- Single add, WORDS=2, req 1, A=0x01FF, B=0x0001 -> byte0 S=0x00, carry 1; rsp_data=0x0200, rsp_cout=0, rsp_id=1; rsp_valid exactly 3 cycles after accept.
- Subtract, req 0, A=0x0100, B=0x0001 -> add_b bytes 0xFE then 0xFF, add_cin=1 on byte0; rsp_data=0x00FF, rsp_cout=1.
- All 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0; no requester starved; one response per 4 cycles.
- Overflow: A=0xFFFF, B=0x0002 add -> rsp_data=0x0001, rsp_cout=1. With ADDSCHED_SAT_EN -> 0xFFFF. Sub 0x0000-0x0001 with ADDSCHED_SAT_EN -> 0x0000, rsp_cout=0.
- Backpressure: rsp_ready=0 for 5 cycles in DONE with req 2 pending -> rsp_data stable, req_ready all 0; after rsp_ready=1, req 2 granted next cycle.
- rst pulsed during RUN byte0 -> all outputs 0 asynchronously, state IDLE, no rsp_valid; next request served with grant search starting from index 0.
